alu_sequencer: RTL and testbench

//  Initiator side of the registered ALU interface (alu_op/in1/in2 -> alu_out/z).

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_sequencer.sv | 118 +++++++++++
 tb/tb_alu_sequencer.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the registered ALU and its sequencer:
//   - opcode width and opcode values understood by the ALU
//   - state encoding of the sequencer FSM
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam int ALU_OP_W = 3;

  localparam logic [ALU_OP_W-1:0] ALU_PASS = 3'd0;
  localparam logic [ALU_OP_W-1:0] ALU_ADD  = 3'd1;
  localparam logic [ALU_OP_W-1:0] ALU_SUB  = 3'd2;
  localparam logic [ALU_OP_W-1:0] ALU_MUL  = 3'd3;
  localparam logic [ALU_OP_W-1:0] ALU_SHL  = 3'd4;

  // One state per ALU pipeline stage, plus the handshake states on each side.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    EXEC = 3'd1,
    RES  = 3'd2,
    FLAG = 3'd3,
    RESP = 3'd4
  } seq_state_t;

endpackage : alu_pkg

// File: rtl/alu_sequencer.sv
// ---------------------------------------------------------------------------
// alu_sequencer
// Initiator for the registered ALU. Takes one operation over a valid/ready
// request port, drives and holds the ALU opcode/operands, waits for the ALU
// result stage and the zero-flag stage, then presents result and flags on a
// valid/ready response port. Strictly one operation in flight.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-high reset
//   req_valid/req_ready      request handshake
//   req_op, req_a, req_b     opcode and operands of the request
//   alu_op, alu_in1, alu_in2 registered drive into the ALU
//   alu_res, alu_z           ALU result and registered zero flag
//   resp_valid/resp_ready    response handshake
//   resp_data, resp_zero     captured result and zero flag
//   resp_err                 request used an opcode the ALU does not define
//   busy                     an operation is in progress
// ---------------------------------------------------------------------------
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int N = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [ALU_OP_W-1:0] req_op,
  input  logic [N-1:0]        req_a,
  input  logic [N-1:0]        req_b,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic [N-1:0]        alu_in1,
  output logic [N-1:0]        alu_in2,
  input  logic [N-1:0]        alu_res,
  input  logic [15:0]         alu_z,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [N-1:0]        resp_data,
  output logic                resp_zero,
  output logic                resp_err,
  output logic                busy
);

  seq_state_t state_q;
  seq_state_t state_d;

  logic accept;
  logic resp_done;

  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign accept    = req_valid && req_ready;
  assign resp_done = (state_q == RESP) && resp_valid && resp_ready;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: the middle states are fixed one-cycle waits matching the
  // ALU's result register and the zero-flag register behind it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = RES;
      RES:     state_d = FLAG;
      FLAG:    state_d = RESP;
      RESP:    if (resp_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ALU drive registers: loaded only on accept and otherwise held, so the
  // ALU keeps seeing the same operation until the next request arrives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_op  <= ALU_PASS;
      alu_in1 <= '0;
      alu_in2 <= '0;
    end else if (accept) begin
      alu_op  <= req_op;
      alu_in1 <= req_a;
      alu_in2 <= req_b;
    end
  end

  // Response registers. The result is taken in RES, one edge before the
  // ALU's zero flag for that same result is available, which is taken in
  // FLAG together with raising resp_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_zero  <= 1'b0;
      resp_err   <= 1'b0;
    end else begin
      if (accept) begin
        resp_err <= (req_op > ALU_SHL);
      end
      if (state_q == RES) begin
        resp_data <= alu_res;
      end
      if (state_q == FLAG) begin
        resp_zero  <= |alu_z;
        resp_valid <= 1'b1;
      end
      if (resp_done) begin
        resp_valid <= 1'b0;
      end
    end
  end

endmodule : alu_sequencer

// File: tb/tb_alu_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_sequencer
// Directed bench for alu_sequencer driving a registered ALU model
// (N = 16, shift amount taken from in2).
// ---------------------------------------------------------------------------
module tb_alu_sequencer;
  import alu_pkg::*;

  localparam int N = 16;

  logic                clk;
  logic                rst;
  logic                req_valid;
  logic                req_ready;
  logic [ALU_OP_W-1:0] req_op;
  logic [N-1:0]        req_a;
  logic [N-1:0]        req_b;
  logic [ALU_OP_W-1:0] alu_op;
  logic [N-1:0]        alu_in1;
  logic [N-1:0]        alu_in2;
  logic [N-1:0]        alu_res;
  logic [15:0]         alu_z;
  logic                resp_valid;
  logic                resp_ready;
  logic [N-1:0]        resp_data;
  logic                resp_zero;
  logic                resp_err;
  logic                busy;

  int pass_count = 0;
  int total_count = 0;

  alu_sequencer #(.N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .alu_op     (alu_op),
    .alu_in1    (alu_in1),
    .alu_in2    (alu_in2),
    .alu_res    (alu_res),
    .alu_z      (alu_z),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_zero  (resp_zero),
    .resp_err   (resp_err),
    .busy       (busy)
  );

  // Clock: 10 time-unit period, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered ALU model: result register, then a zero-flag register fed
  // from the result register. Undefined opcodes pass in1.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_res <= '0;
      alu_z   <= '0;
    end else begin
      case (alu_op)
        ALU_ADD: alu_res <= alu_in1 + alu_in2;
        ALU_SUB: alu_res <= alu_in1 - alu_in2;
        ALU_MUL: alu_res <= alu_in1 * alu_in2;
        ALU_SHL: alu_res <= alu_in1 << alu_in2[3:0];
        default: alu_res <= alu_in1;
      endcase
      alu_z <= {15'd0, (alu_res == '0)};
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total_count++;
    assert (observed === expected) pass_count++;
    else $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
  endtask

  // Present a request and hold it until accepted (bounded). Returns one
  // cycle after the accept edge with req_valid dropped.
  task automatic applyStimulus(input string tag, input logic [2:0] op,
                               input logic [N-1:0] a, input logic [N-1:0] b);
    int waited;
    logic accepted;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_valid = 1'b1;
    waited    = 0;
    accepted  = 1'b0;
    while (!accepted && waited < 20) begin
      accepted = req_ready;
      @(posedge clk);
      #1;
      waited++;
    end
    req_valid = 1'b0;
    checkOutput({tag, "_accepted"}, {31'd0, accepted}, 32'd1);
  endtask

  // Count cycles from the accept edge until resp_valid (bounded).
  task automatic waitResponse(output int cycles);
    cycles = 0;
    while (!resp_valid && cycles < 12) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  // Full transaction with resp_ready high.
  task automatic runOp(input string tag, input logic [2:0] op,
                       input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [N-1:0] exp_data, input logic exp_zero,
                       input logic exp_err);
    int cycles;
    applyStimulus(tag, op, a, b);
    waitResponse(cycles);
    checkOutput({tag, "_latency"}, cycles, 32'd3);
    checkOutput({tag, "_data"}, {16'd0, resp_data}, {16'd0, exp_data});
    checkOutput({tag, "_zero"}, {31'd0, resp_zero}, {31'd0, exp_zero});
    checkOutput({tag, "_err"}, {31'd0, resp_err}, {31'd0, exp_err});
    @(posedge clk);
    #1;
    checkOutput({tag, "_valid_drop"}, {31'd0, resp_valid}, 32'd0);
  endtask

  initial begin
    int cycles;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_op     = '0;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 1'b1;

    // Reset state
    #12;
    checkOutput("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    checkOutput("rst_resp_data", {16'd0, resp_data}, 32'd0);
    checkOutput("rst_alu_op", {29'd0, alu_op}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("idle_req_ready", {31'd0, req_ready}, 32'd1);

    // Basic operations
    runOp("add_5_7", ALU_ADD, 16'd5, 16'd7, 16'd12, 1'b0, 1'b0);
    runOp("sub_9_9", ALU_SUB, 16'd9, 16'd9, 16'd0, 1'b1, 1'b0);
    runOp("sub_3_5", ALU_SUB, 16'd3, 16'd5, 16'hFFFE, 1'b0, 1'b0);
    runOp("mul_300", ALU_MUL, 16'd300, 16'd300, 16'd24464, 1'b0, 1'b0);
    runOp("shl_12", ALU_SHL, 16'h0012, 16'd8, 16'h1200, 1'b0, 1'b0);
    runOp("op6_err", 3'd6, 16'h00AA, 16'h0003, 16'h00AA, 1'b0, 1'b1);

    // Backpressure with a second request waiting
    resp_ready = 1'b0;
    applyStimulus("bp_first", ALU_ADD, 16'd2, 16'd3);
    waitResponse(cycles);
    checkOutput("bp_latency", cycles, 32'd3);
    req_op    = ALU_SUB;
    req_a     = 16'd10;
    req_b     = 16'd4;
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checkOutput("bp_req_ready", {31'd0, req_ready}, 32'd0);
      checkOutput("bp_resp_valid", {31'd0, resp_valid}, 32'd1);
      checkOutput("bp_resp_data", {16'd0, resp_data}, 32'd5);
      checkOutput("bp_alu_op", {29'd0, alu_op}, {29'd0, ALU_ADD});
      checkOutput("bp_alu_in1", {16'd0, alu_in1}, 32'd2);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("bp_handshake_valid", {31'd0, resp_valid}, 32'd0);
    checkOutput("bp_idle_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    checkOutput("bp_second_busy", {31'd0, busy}, 32'd1);
    checkOutput("bp_second_op", {29'd0, alu_op}, {29'd0, ALU_SUB});
    checkOutput("bp_second_in1", {16'd0, alu_in1}, 32'd10);
    waitResponse(cycles);
    checkOutput("bp_second_latency", cycles, 32'd3);
    checkOutput("bp_second_data", {16'd0, resp_data}, 32'd6);
    @(posedge clk);
    #1;

    // Reset pulse while in FLAG
    applyStimulus("rst_mid", ALU_ADD, 16'd4, 16'd4);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    checkOutput("rst_mid_busy_before", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("rst_mid_resp_valid", {31'd0, resp_valid}, 32'd0);
    checkOutput("rst_mid_alu_op", {29'd0, alu_op}, 32'd0);
    checkOutput("rst_mid_alu_in1", {16'd0, alu_in1}, 32'd0);
    checkOutput("rst_mid_busy", {31'd0, busy}, 32'd0);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    runOp("add_1_1", ALU_ADD, 16'd1, 16'd1, 16'd2, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", pass_count, total_count);
    $finish;
  end

endmodule : tb_alu_sequencer
